mix_columns_seq: RTL
====================

# mix_columns_seq

Sequential, parametrised MixColumns/InvMixColumns engine for the AES datapath. It accepts one 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock. It returns the transformed state over a second valid/ready handshake. It is the multi-cycle successor of the combinational MixColumns block: the mode bit selects forward or inverse, and the column throughput can be traded against area.

## Interface
- COLS_PER_CYCLE, default 1: columns transformed per clock; legal values 1, 2, 4; any other value is an elaboration error.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data and in_mode are valid.
- in_ready  output  1  block can accept a state this cycle.
- in_data  input  128  AES state, column-major: column c = bits [127-32c -: 32], byte r of a column = bits [31-8r -: 8] within it.
- in_mode  input  1  0 = MixColumns (matrix 02 03 01 01), 1 = InvMixColumns (matrix 0e 0b 0d 09).
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  128  transformed state, same byte ordering as in_data.

## Operation
- N = 4 / COLS_PER_CYCLE processing cycles per state.
- FSM states:
  - IDLE: in_ready = 1.
    - in_valid & in_ready: latch in_data into the working register, latch in_mode, col_idx = 0, go to BUSY.
  - BUSY: each cycle, replace columns col_idx .. col_idx+COLS_PER_CYCLE-1 of the working register with their transformed values, then col_idx += COLS_PER_CYCLE.
    - After the cycle that processes column 3, go to DONE.
    - in_ready = 0 throughout.
  - DONE: out_valid = 1; out_data = working register.
    - out_ready = 1: the result is consumed.
    - in_ready = out_ready in DONE, so a new state can be accepted in the same cycle the result is consumed (go to BUSY). Otherwise go to IDLE.
- Arithmetic is GF(2^8) with polynomial 0x11B. xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0), truncated to 8 bits. Multiples 09/0b/0d/0e are built from xtime chains.
- in_mode and in_data are sampled only at acceptance. Changes while BUSY/DONE have no effect.
- out_data is stable while out_valid = 1 and out_ready = 0, for any number of cycles.
- col_idx is 2 bits and wraps to 0 after column 3. It is only meaningful in BUSY.
- Reset (rst_n = 0 at any time, including mid-BUSY or in DONE with a result pending) is immediate and asynchronous:
  - go to IDLE; out_valid = 0; in_ready = 1 after release;
  - working register, out_data and col_idx = 0; latched mode = 0.
  - In-flight work is discarded, not completed.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 128'h0.
- Acceptance edge = rising edge with in_valid & in_ready.
- out_valid rises after N+1 rising edges counted from the acceptance edge (inclusive):
  - COLS_PER_CYCLE = 1: 5 edges.
  - COLS_PER_CYCLE = 2: 3 edges.
  - COLS_PER_CYCLE = 4: 2 edges.
- Throughput with out_ready held 1: one state per N+1 cycles (back-to-back accept in DONE).
- No combinational path from in_* to out_*.
- in_ready depends combinationally only on state and out_ready.

## Test plan
- Forward, each COLS_PER_CYCLE value: in_data = 6353e08c0960e104cd70b751bacad0e7, mode 0, out_ready = 1 -> out_data = 5f72641557f5bc92f7be3b291db9f91a, with out_valid at exactly the N+1 edge count.
- Inverse round-trip: in_data = 5f72641557f5bc92f7be3b291db9f91a, mode 1 -> 6353e08c0960e104cd70b751bacad0e7.
- Second vector: d4bf5d30e0b452aeb84111f11e2798e5, mode 0 -> 046681e5e0cb199a48f8d37a2806264c. Feed that output back with mode 1 -> original input.
- Backpressure: hold out_ready = 0 for 7 cycles in DONE.
  - out_valid stays 1; out_data is unchanged; in_ready = 0; in_valid pulses are ignored.
  - Then pulse out_ready -> the next state is accepted in the same cycle.
- Mid-operation changes: toggle in_mode and in_data during BUSY -> result matches the values latched at acceptance.
- Reset: assert rst_n = 0 in BUSY, then again in DONE.
  - Each time: out_valid = 0 and out_data = 0 immediately, without waiting for a clock edge.
  - After release: in_ready = 1, and a fresh vector completes correctly.

Source files
------------

// File: rtl/mix_columns_seq.sv
// Multi-cycle AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per clock.
// Ports: clk, rst_n (async low); in_valid/in_ready/in_data/in_mode accept a 128-bit
// column-major state and a mode (0 fwd, 1 inv); out_valid/out_ready/out_data return it.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
            COLS_PER_CYCLE != 4) begin : g_bad_cfg
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Column pointer step; 4 truncates to 0, which is the intended wrap.
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [127:0]  work;
    logic [127:0]  next_work;
    logic          mode;
    logic [1:0]    col_idx;
    logic          last;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through either matrix. Inverse coefficients are sums of
    // x2/x4/x8 chains: 0e=8^4^2, 0b=8^2^1, 0d=8^4^1, 09=8^1.
    function automatic logic [31:0] mix_col(input logic [31:0] col,
                                            input logic        inv);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] b  [4];
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2[i] = xt(a[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
        end
        for (int r = 0; r < 4; r++) begin
            int r1;
            int r2;
            int r3;
            r1 = (r + 1) % 4;
            r2 = (r + 2) % 4;
            r3 = (r + 3) % 4;
            if (!inv) begin
                b[r] = x2[r] ^ (x2[r1] ^ a[r1]) ^ a[r2] ^ a[r3];
            end else begin
                b[r] = (x8[r]  ^ x4[r]  ^ x2[r])
                     ^ (x8[r1] ^ x2[r1] ^ a[r1])
                     ^ (x8[r2] ^ x4[r2] ^ a[r2])
                     ^ (x8[r3] ^ a[r3]);
            end
        end
        res = {b[0], b[1], b[2], b[3]};
        return res;
    endfunction

    // col_idx is always a multiple of COLS_PER_CYCLE, so col_idx+k never exceeds 3.
    always_comb begin
        next_work = work;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            next_work[127 - 32*(int'(col_idx) + k) -: 32] =
                mix_col(work[127 - 32*(int'(col_idx) + k) -: 32], mode);
        end
    end

    assign last = (int'(col_idx) + COLS_PER_CYCLE) == 4;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_data = work;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            mode      <= 1'b0;
            col_idx   <= 2'd0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work    <= in_data;
                        mode    <= in_mode;
                        col_idx <= 2'd0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    work    <= next_work;
                    col_idx <= col_idx + STEP;
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            work    <= in_data;
                            mode    <= in_mode;
                            col_idx <= 2'd0;
                            state   <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
